// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

   // Controller states: waiting for a request, or iterating one quotient bit per clock.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Default operand width for the tile/sprite datapath.
   localparam int DEF_N = 5;

   // Iteration counter width: it must hold values from N down to 0.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_restoring_divider_addsub.sv
// Ripple-carry adder/subtractor. ADDSUB=1 selects A - B (two's complement);
// Cout is then the no-borrow flag (1 when A >= B).
module AddSubNbit #(
   parameter int n = 4
) (
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   input  logic         ADDSUB,
   output logic [n-1:0] S,
   output logic         Cout
);

   logic [n:0]   c;
   logic [n-1:0] bx;

   // Subtract mode inverts B and injects the +1 through the carry-in.
   assign bx   = B ^ {n{ADDSUB}};
   assign c[0] = ADDSUB;

   // One full-adder slice per bit.
   for (genvar i = 0; i < n; i++) begin : g_fa
      assign S[i]   = A[i] ^ bx[i] ^ c[i];
      assign c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
   end

   assign Cout = c[n];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned N-bit restoring divider: one trial subtraction per clock
// through a single N+1-bit subtractor. Result appears N cycles after acceptance;
// a zero divisor is resolved immediately without entering RUN.
module seq_restoring_divider
   import divider_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         Start,
   input  logic [N-1:0] DIVIDEND,
   input  logic [N-1:0] DIVISOR,
   output logic [N-1:0] Q,
   output logic [N-1:0] R,
   output logic         Busy,
   output logic         Done,
   output logic         DivByZero
);

   localparam int CW = cnt_w(N);

   state_t        state, state_nx;
   logic [N:0]    a;          // partial remainder
   logic [N-1:0]  qs;         // dividend shifting out, quotient shifting in
   logic [N-1:0]  d;          // latched divisor
   logic [CW-1:0] cnt;        // iterations left

   logic          load_op;    // accept a request with a non-zero divisor
   logic          zero_div;   // accept a request with a zero divisor
   logic          last_iter;  // final iteration this edge
   logic          busy_c;

   logic [N:0]    trial_in;
   logic [N:0]    diff;
   logic          no_borrow;
   logic [N:0]    a_nx;
   logic [N-1:0]  qs_nx;
   logic          unused_a_msb;

   // Shifted partial remainder minus divisor; restoring keeps A < D so only the
   // low N bits of A ever feed the next shift.
   assign trial_in     = {a[N-1:0], qs[N-1]};
   assign unused_a_msb = a[N];

   AddSubNbit #(.n(N + 1)) u_sub (
      .A      (trial_in),
      .B      ({1'b0, d}),
      .ADDSUB (1'b1),
      .S      (diff),
      .Cout   (no_borrow)
   );

   assign a_nx  = no_borrow ? diff : trial_in;
   assign qs_nx = {qs[N-2:0], no_borrow};

   // State register.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // Next-state and control decode.
   always_comb begin
      state_nx  = state;
      load_op   = 1'b0;
      zero_div  = 1'b0;
      last_iter = 1'b0;
      busy_c    = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               if (DIVISOR != '0) begin
                  load_op  = 1'b1;
                  state_nx = RUN;
               end else begin
                  zero_div = 1'b1;
               end
            end
         end
         RUN: begin
            busy_c = 1'b1;
            if (cnt == CW'(1)) begin
               last_iter = 1'b1;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign Busy = busy_c;

   // Iteration datapath: load operands on accept, then one restoring step per clock.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         a   <= '0;
         qs  <= '0;
         d   <= '0;
         cnt <= '0;
      end else if (load_op) begin
         a   <= '0;
         qs  <= DIVIDEND;
         d   <= DIVISOR;
         cnt <= CW'(N);
      end else if (state == RUN) begin
         a   <= a_nx;
         qs  <= qs_nx;
         cnt <= cnt - CW'(1);
      end
   end

   // Result registers hold until the next completion; Done pulses for one cycle.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         Q         <= '0;
         R         <= '0;
         DivByZero <= 1'b0;
         Done      <= 1'b0;
      end else begin
         Done <= zero_div | last_iter;
         if (zero_div) begin
            Q         <= '1;
            R         <= DIVIDEND;
            DivByZero <= 1'b1;
         end else if (last_iter) begin
            Q         <= qs_nx;
            R         <= a_nx[N-1:0];
            DivByZero <= 1'b0;
         end
      end
   end

endmodule
